// File: rtl/io_bridge_if.sv
// Upstream Wishbone port of the I/O bridge: CPU-side request and completion.
interface io_bridge_if #(
  parameter int ADRW = 17
);
  logic            cyc_i;
  logic            stb_i;
  logic            we_i;
  logic [ADRW-1:0] adr_i;
  logic [31:0]     dat_i;
  logic [3:0]      sel_i;
  logic [31:0]     dat_o;
  logic            ack_o;
  logic            err_o;

  // CPU side drives the request and receives the completion.
  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o
  );

  // Bridge side receives the request and returns the completion.
  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/io_bridge.sv
// Wishbone I/O bridge: decodes a 4-bit selector into one-hot slave strobes,
// times out silent slaves with a bus error, and hosts a local register bank
// (ID, interrupt mask/pending, timeout capture) on channel 0.
module io_bridge #(
  parameter int         NSLAVES = 16,
  parameter int         ADRW    = 17,
  parameter int         SELLO   = 12,
  parameter int         TIMEOUT = 255,
  parameter logic [7:0] VERSION = 8'h02
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  io_bridge_if.slave              bus,
  output logic                    m_cyc_o,
  output logic [NSLAVES-1:0]      m_stb_o,
  output logic                    m_we_o,
  output logic [ADRW-1:0]         m_adr_o,
  output logic [31:0]             m_dat_o,
  output logic [3:0]              m_sel_o,
  input  logic [32*NSLAVES-1:0]   m_dat_i,
  input  logic [NSLAVES-1:0]      m_ack_i,
  input  logic [NSLAVES-1:0]      m_err_i,
  input  logic [NSLAVES-1:0]      irq_i,
  output logic                    irq_o,
  output logic [NSLAVES-1:0]      irq_vec_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ERR} state_t;

  localparam logic [15:0]        TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]         NS_ID   = 8'(NSLAVES);
  localparam logic [4:0]         NS_LIM  = 5'(NSLAVES);
  localparam logic [NSLAVES-1:0] IRQ_USE = {{(NSLAVES-1){1'b1}}, 1'b0};

  state_t              state_q, state_d;
  logic [3:0]          sel_q;
  logic [15:0]         cnt_q;
  logic [15:0]         ack_ext, err_ext, stb_ext;
  logic [31:0]         slv_dat [16];
  logic [31:0]         mask_q;
  logic                to_valid_q;
  logic [ADRW-1:0]     to_adr_q;
  logic [NSLAVES-1:0]  pend;
  logic [31:0]         local_rd;
  logic                sel_oob;
  logic                start, local_go, ext_done, to_hit;

  // Widen per-slave vectors to the full 16-entry selector space; absent slaves read as 0.
  always_comb begin
    ack_ext = 16'(m_ack_i);
    err_ext = 16'(m_err_i);
    for (int n = 0; n < 16; n++) slv_dat[n] = '0;
    for (int n = 0; n < NSLAVES; n++) slv_dat[n] = m_dat_i[32*n +: 32];
  end

  assign sel_oob = {1'b0, sel_q} >= NS_LIM;
  assign pend    = irq_i & mask_q[NSLAVES-1:0] & IRQ_USE;
  assign irq_o   = |irq_vec_o;

  // Local bank read mux, indexed by the latched word address.
  always_comb begin
    local_rd = '0;
    case (m_adr_o[3:2])
      2'd0: local_rd = {16'hB10C, NS_ID, VERSION};
      2'd1: local_rd = mask_q;
      2'd2: local_rd = 32'(pend);
      default: begin
        local_rd     = 32'(to_adr_q);
        local_rd[31] = to_valid_q;
      end
    endcase
  end

  // Next-state and bus outputs; BUSY resolves in strict priority order.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    start      = 1'b0;
    local_go   = 1'b0;
    ext_done   = 1'b0;
    to_hit     = 1'b0;
    m_cyc_o    = 1'b0;
    stb_ext    = '0;
    bus.ack_o  = 1'b0;
    bus.err_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cyc_i && bus.stb_i) begin
          start   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        m_cyc_o = 1'b1;
        if (sel_q != 4'd0) stb_ext = 16'd1 << sel_q;
        if (!bus.cyc_i)               state_d = S_IDLE;
        else if (sel_oob)             state_d = S_ERR;
        else if (sel_q == 4'd0) begin local_go = 1'b1; state_d = S_DONE; end
        else if (err_ext[sel_q])      state_d = S_ERR;
        else if (ack_ext[sel_q]) begin ext_done = 1'b1; state_d = S_DONE; end
        else if (cnt_q == TO_LAST) begin to_hit = 1'b1; state_d = S_ERR; end
      end
      S_DONE: begin
        bus.ack_o = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        bus.err_o = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
    m_stb_o = stb_ext[NSLAVES-1:0];
  end

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // BUSY cycle counter, cleared when a request is accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_i)                 cnt_q <= '0;
    else if (start)             cnt_q <= '0;
    else if (state_q == S_BUSY) cnt_q <= cnt_q + 16'd1;
  end

  // Latched copy of the accepted request, presented to the slaves during BUSY.
  always_ff @(posedge clk_i) begin
    // NOTE: pure datapath copies carry no reset; they only matter while BUSY qualifies them.
    if (start) begin
      sel_q   <= bus.adr_i[SELLO+3:SELLO];
      m_we_o  <= bus.we_i;
      m_adr_o <= bus.adr_i;
      m_dat_o <= bus.dat_i;
      m_sel_o <= bus.sel_i;
    end
  end

  // Read data, local register bank and the registered interrupt vector.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus.dat_o  <= '0;
      mask_q     <= '0;
      to_valid_q <= 1'b0;
      to_adr_q   <= '0;
      irq_vec_o  <= '0;
    end else begin
      irq_vec_o <= pend;
      if (state_q == S_BUSY && state_d == S_ERR) bus.dat_o <= 32'hDEAD_BEEF;
      else if (local_go && !m_we_o)              bus.dat_o <= local_rd;
      else if (ext_done && !m_we_o)              bus.dat_o <= slv_dat[sel_q];
      if (local_go && m_we_o) begin
        if (m_adr_o[3:2] == 2'd1) begin
          for (int b = 0; b < 4; b++)
            if (m_sel_o[b]) mask_q[8*b +: 8] <= m_dat_o[8*b +: 8];
        end
        if (m_adr_o[3:2] == 2'd3) begin
          to_valid_q <= 1'b0;
          to_adr_q   <= '0;
        end
      end
      if (to_hit) begin
        to_valid_q <= 1'b1;
        to_adr_q   <= m_adr_o;
      end
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed scenarios plus randomized
// transactions checked against a transaction-level model of the bridge.
module tb_io_bridge;

  localparam int TO = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  io_bridge_if #(.ADRW(17)) bus ();
  io_bridge_if #(.ADRW(17)) bus8 ();

  logic          m_cyc_o, m_we_o;
  logic [15:0]   m_stb_o, irq_vec_o;
  logic [16:0]   m_adr_o;
  logic [31:0]   m_dat_o;
  logic [3:0]    m_sel_o;
  logic [511:0]  m_dat_i;
  logic [15:0]   m_ack_i, m_err_i, irq_i;
  logic          irq_o;

  logic          m8_cyc, m8_we, irq8_o;
  logic [7:0]    m8_stb, irq8_vec;
  logic [16:0]   m8_adr;
  logic [31:0]   m8_dat;
  logic [3:0]    m8_sel;
  logic [255:0]  m8_dat_i = '0;
  logic [7:0]    m8_zero = '0;

  io_bridge #(.NSLAVES(16), .ADRW(17), .SELLO(12), .TIMEOUT(TO), .VERSION(8'h02)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .m_err_i(m_err_i), .irq_i(irq_i), .irq_o(irq_o), .irq_vec_o(irq_vec_o)
  );

  io_bridge #(.NSLAVES(8), .ADRW(17), .SELLO(12), .TIMEOUT(TO), .VERSION(8'h02)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus8),
    .m_cyc_o(m8_cyc), .m_stb_o(m8_stb), .m_we_o(m8_we), .m_adr_o(m8_adr),
    .m_dat_o(m8_dat), .m_sel_o(m8_sel), .m_dat_i(m8_dat_i), .m_ack_i(m8_zero),
    .m_err_i(m8_zero), .irq_i(m8_zero), .irq_o(irq8_o), .irq_vec_o(irq8_vec)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] mask_m   = '0;
  logic        to_val_m = 1'b0;
  logic [16:0] to_adr_m = '0;
  logic [31:0] dat_m    = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] local_val(input logic [1:0] word);
    case (word)
      2'd0:    return {16'hB10C, 8'd16, 8'h02};
      2'd1:    return mask_m;
      2'd2:    return {16'h0, irq_i & mask_m[15:0] & 16'hFFFE};
      default: return {to_val_m, 14'h0, to_adr_m};
    endcase
  endfunction

  // mode: 0 slave acks after k BUSY cycles, 1 slave errors after k, 2 slave silent.
  task automatic access(input logic we, input logic [3:0] s, input logic [16:0] low,
                        input logic [31:0] wdat, input logic [3:0] be,
                        input int mode, input int k, input logic [31:0] sdata);
    logic [16:0] adr;
    logic [15:0] onehot;
    int c, exp_c;
    bit done, got_ack, got_err, exp_err;
    adr = low;
    adr[15:12] = s;
    onehot = (s == 4'd0) ? 16'h0 : (16'd1 << s);
    for (int n = 0; n < 16; n++) m_dat_i[32*n +: 32] = $urandom;
    m_dat_i[32*s +: 32] = sdata;
    @(negedge clk_i);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
    bus.adr_i = adr;  bus.dat_i = wdat; bus.sel_i = be;
    c = 0; done = 0; got_ack = 0; got_err = 0;
    while (!done && c < 40) begin
      @(posedge clk_i);
      c++;
      @(negedge clk_i);
      if (bus.ack_o || bus.err_o) begin
        done = 1; got_ack = bus.ack_o; got_err = bus.err_o;
      end else begin
        check("stb", m_stb_o, onehot);
        check("cyc", m_cyc_o, 1'b1);
        if (c == 1) check("copy", {m_we_o, m_adr_o, m_dat_o, m_sel_o}, {we, adr, wdat, be});
        m_ack_i = 16'($urandom) & ~onehot;
        m_err_i = 16'($urandom) & ~onehot;
        if (s != 4'd0 && c - 1 == k && mode == 0) m_ack_i = m_ack_i | onehot;
        if (s != 4'd0 && c - 1 == k && mode == 1) m_err_i = m_err_i | onehot;
      end
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    m_ack_i = '0; m_err_i = '0;
    // Expected outcome from the transaction rules.
    if (s == 4'd0) begin
      exp_c = 2; exp_err = 0;
      if (!we) dat_m = local_val(adr[3:2]);
      else if (adr[3:2] == 2'd1) begin
        for (int b = 0; b < 4; b++) if (be[b]) mask_m[8*b +: 8] = wdat[8*b +: 8];
      end else if (adr[3:2] == 2'd3) begin
        to_val_m = 0; to_adr_m = '0;
      end
    end else if (mode == 0) begin
      exp_c = 2 + k; exp_err = 0;
      if (!we) dat_m = sdata;
    end else if (mode == 1) begin
      exp_c = 2 + k; exp_err = 1; dat_m = 32'hDEADBEEF;
    end else begin
      exp_c = TO + 1; exp_err = 1; dat_m = 32'hDEADBEEF;
      to_val_m = 1; to_adr_m = adr;
    end
    check("cycle", c, exp_c);
    check("ack", got_ack, !exp_err);
    check("err", got_err, exp_err);
    check("dat_o", bus.dat_o, dat_m);
  endtask

  task automatic irq_step(input logic [15:0] v);
    logic [15:0] e;
    @(negedge clk_i);
    irq_i = v;
    @(posedge clk_i);
    @(negedge clk_i);
    e = v & mask_m[15:0] & 16'hFFFE;
    check("irq_vec", irq_vec_o, e);
    check("irq_o", irq_o, e != 0);
  endtask

  initial begin
    int c;
    bit done, got_err;
    logic [3:0] s;
    int mode;
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = '0;
    bus8.cyc_i = 0; bus8.stb_i = 0; bus8.we_i = 0; bus8.adr_i = '0; bus8.dat_i = '0; bus8.sel_i = '0;
    m_dat_i = '0; m_ack_i = '0; m_err_i = '0; irq_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_out", {bus.ack_o, bus.err_o, m_cyc_o, m_stb_o, irq_o, irq_vec_o}, '0);
    check("rst_dat", bus.dat_o, 32'h0);
    rst_i = 1'b1;

    // Directed scenarios.
    access(0, 4'd0, 17'h00000, 32'h0, 4'hF, 0, 0, 32'h0);
    check("id", bus.dat_o, 32'hB10C1002);
    access(0, 4'd2, 17'h00010, 32'h0, 4'hF, 0, 3, 32'h12345678);
    access(0, 4'd5, 17'h10A34, 32'h0, 4'hF, 2, 0, 32'h0);
    access(0, 4'd0, 17'h0000C, 32'h0, 4'hF, 0, 0, 32'h0);
    check("to_stat", bus.dat_o, 32'h80015A34);
    access(1, 4'd0, 17'h0000C, 32'h0, 4'hF, 0, 0, 32'h0);
    access(0, 4'd0, 17'h0000C, 32'h0, 4'hF, 0, 0, 32'h0);
    access(0, 4'd3, 17'h00020, 32'h0, 4'hF, 1, 1, 32'h55555555);
    access(0, 4'd4, 17'h00000, 32'h0, 4'hF, 0, TO - 1, 32'hCAFEF00D);

    // Out-of-range selector on an 8-slave bridge.
    @(negedge clk_i);
    bus8.cyc_i = 1; bus8.stb_i = 1; bus8.adr_i = 17'h0F000;
    c = 0; done = 0; got_err = 0;
    while (!done && c < 40) begin
      @(posedge clk_i);
      c++;
      @(negedge clk_i);
      if (bus8.ack_o || bus8.err_o) begin
        done = 1; got_err = bus8.err_o;
      end else check("oob_stb", m8_stb, 8'h00);
    end
    bus8.cyc_i = 0; bus8.stb_i = 0;
    check("oob_cycle", c, 2);
    check("oob_err", got_err, 1'b1);
    check("oob_dat", bus8.dat_o, 32'hDEADBEEF);

    // Interrupts.
    access(1, 4'd0, 17'h00004, 32'h00000104, 4'hF, 0, 0, 32'h0);
    irq_step(16'h0106);
    access(0, 4'd0, 17'h00008, 32'h0, 4'hF, 0, 0, 32'h0);
    check("irq_pend", bus.dat_o, 32'h104);

    // Abort: cyc_i dropped while BUSY.
    @(negedge clk_i);
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 17'h06000;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    bus.cyc_i = 0; bus.stb_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("abort_ack_err", {bus.ack_o, bus.err_o, m_cyc_o}, 3'b000);
    end
    check("abort_dat", bus.dat_o, dat_m);

    // Reset in the middle of a BUSY access.
    @(negedge clk_i);
    bus.cyc_i = 1; bus.stb_i = 1; bus.adr_i = 17'h04000;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("mid_rst_out", {bus.ack_o, bus.err_o, m_cyc_o, m_stb_o, irq_o, irq_vec_o}, '0);
    check("mid_rst_dat", bus.dat_o, 32'h0);
    rst_i = 1; bus.cyc_i = 0; bus.stb_i = 0;
    mask_m = '0; to_val_m = 0; to_adr_m = '0; dat_m = '0;
    access(0, 4'd0, 17'h00000, 32'h0, 4'hF, 0, 0, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 160; i++) begin
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) s = 4'd0;
      mode = $urandom_range(0, 9);
      mode = (mode < 6) ? 0 : (mode < 8) ? 1 : 2;
      if ($urandom_range(0, 3) == 0) irq_step(16'($urandom));
      access(1'($urandom_range(0, 1)), s, 17'($urandom), $urandom, 4'($urandom_range(0, 15)),
             mode, $urandom_range(0, TO - 1), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
